// File: rtl/mp3_ram_arb_pkg.sv
// Shared types and defaults for the MP3 RAM arbiter: FSM states, read-return owners,
// and the burst-length clamp used when a port-B command is accepted.
package mp3_ram_arb_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

  // A zero count still moves one beat; oversize counts saturate at the burst limit.
  function automatic logic [4:0] clamp_burst(input logic [4:0] count, input int max_burst);
    if (count == 5'd0) return 5'd1;
    if (int'(count) > max_burst) return 5'(max_burst);
    return count;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter: on a tie the port that did not win last time is
// granted. Grant is one-hot, bit 0 = port A, bit 1 = port B.
module rr_arb2
  import mp3_ram_arb_pkg::*;
(
  input  logic       req_a,
  input  logic       req_b,
  input  owner_t     last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req_a && req_b) begin
      grant = (last_grant == OWN_A) ? 2'b10 : 2'b01;
    end else if (req_a) begin
      grant = 2'b01;
    end else if (req_b) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/mp3_ram_arbiter.sv
// Shares the single-port program/data RAM between the CPU Avalon-MM port (A) and the
// audio read-burst port (B), with a bounded hold so A is never starved by a long burst.
module mp3_ram_arbiter
  import mp3_ram_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 16,
  parameter int MAX_HOLD  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic                a_read,
  input  logic                a_write,
  input  logic [DATA_W/8-1:0] a_byteenable,
  input  logic [DATA_W-1:0]   a_writedata,
  output logic                a_waitrequest,
  output logic [DATA_W-1:0]   a_readdata,
  output logic                a_readdatavalid,
  input  logic [ADDR_W-1:0]   b_address,
  input  logic                b_read,
  input  logic [4:0]          b_burstcount,
  output logic                b_waitrequest,
  output logic [DATA_W-1:0]   b_readdata,
  output logic                b_readdatavalid,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic [DATA_W-1:0]   ram_writedata,
  input  logic [DATA_W-1:0]   ram_readdata
);

  localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

  state_t            state, state_next;
  owner_t            last_grant, rd_owner;
  logic [4:0]        beats_left;
  logic [4:0]        burst_count;
  logic [HOLD_W-1:0] hold_cnt;
  logic [ADDR_W-1:0] burst_addr;
  logic              rd_valid;
  logic              req_a, req_b;
  logic [1:0]        arb_grant;
  logic              grant_a, accept_b, beat_b;

  // Requests are masked while reset is held so the RAM is deselected immediately.
  assign req_a       = reset_n & (a_read | a_write);
  assign req_b       = reset_n & b_read;
  assign burst_count = clamp_burst(b_burstcount, MAX_BURST);

  rr_arb2 u_rr_arb2 (
    .req_a      (req_a),
    .req_b      (req_b),
    .last_grant (last_grant),
    .grant      (arb_grant)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= OWN_B;
      beats_left <= '0;
      hold_cnt   <= '0;
      burst_addr <= '0;
      rd_valid   <= 1'b0;
      rd_owner   <= OWN_A;
    end else begin
      state    <= state_next;
      rd_valid <= ram_chipselect && !ram_write;
      rd_owner <= grant_a ? OWN_A : OWN_B;
      if (grant_a) begin
        last_grant <= OWN_A;
        hold_cnt   <= '0;
      end else if (accept_b) begin
        last_grant <= OWN_B;
        burst_addr <= b_address + ADDR_W'(1);
        beats_left <= burst_count - 5'd1;
        hold_cnt   <= HOLD_W'(1);
      end else if (beat_b) begin
        burst_addr <= burst_addr + ADDR_W'(1);
        beats_left <= beats_left - 5'd1;
        if (hold_cnt != HOLD_W'(MAX_HOLD)) hold_cnt <= hold_cnt + HOLD_W'(1);
        if (beats_left == 5'd1) last_grant <= OWN_B;
      end
    end
  end

  // Inside a burst, A only gets the slot once B has used its full hold allowance.
  always_comb begin
    state_next = state;
    grant_a    = 1'b0;
    accept_b   = 1'b0;
    beat_b     = 1'b0;
    case (state)
      IDLE: begin
        grant_a  = arb_grant[0];
        accept_b = arb_grant[1];
        if (accept_b && (burst_count > 5'd1)) state_next = BURST;
      end
      BURST: begin
        grant_a = req_a && (hold_cnt == HOLD_W'(MAX_HOLD));
        beat_b  = !grant_a;
        if (beat_b && (beats_left == 5'd1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ram_chipselect = 1'b0;
    ram_write      = 1'b0;
    ram_address    = a_address;
    ram_byteenable = '1;
    ram_writedata  = a_writedata;
    if (grant_a) begin
      ram_chipselect = 1'b1;
      ram_write      = a_write;
      if (a_write) ram_byteenable = a_byteenable;
    end else if (accept_b) begin
      ram_chipselect = 1'b1;
      ram_address    = b_address;
    end else if (beat_b) begin
      ram_chipselect = 1'b1;
      ram_address    = burst_addr;
    end
    a_waitrequest   = !grant_a;
    b_waitrequest   = !accept_b;
    a_readdatavalid = rd_valid && (rd_owner == OWN_A);
    b_readdatavalid = rd_valid && (rd_owner == OWN_B);
  end

  assign a_readdata = ram_readdata;
  assign b_readdata = ram_readdata;

endmodule

// File: tb/tb_mp3_ram_arbiter.sv
// Self-checking bench for mp3_ram_arbiter: directed cycle tables for the RAM pins and a
// per-port scoreboard of expected read data, drained by a monitor on readdatavalid.
module tb_mp3_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] a_address;
  logic        a_read, a_write;
  logic [3:0]  a_byteenable;
  logic [31:0] a_writedata;
  logic        a_waitrequest;
  logic [31:0] a_readdata;
  logic        a_readdatavalid;
  logic [11:0] b_address;
  logic        b_read;
  logic [4:0]  b_burstcount;
  logic        b_waitrequest;
  logic [31:0] b_readdata;
  logic        b_readdatavalid;
  logic        ram_chipselect, ram_write;
  logic [11:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_writedata;
  logic [31:0] ram_readdata;

  logic        preload;
  logic [31:0] mem [0:4095];
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  int          checks = 0;
  int          errors = 0;

  logic [11:0] hold_addr [13] = '{12'h100, 12'h101, 12'h102, 12'h103, 12'h200, 12'h104,
                                  12'h105, 12'h106, 12'h107, 12'h200, 12'h108, 12'h109, 12'h200};
  logic        hold_awr  [13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                                  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [11:0] wrap_addr [5]  = '{12'hFFE, 12'hFFF, 12'h000, 12'h001, 12'h020};
  logic        wrap_bwr  [5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  always #5 clk = ~clk;

  mp3_ram_arbiter dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .a_address       (a_address),
    .a_read          (a_read),
    .a_write         (a_write),
    .a_byteenable    (a_byteenable),
    .a_writedata     (a_writedata),
    .a_waitrequest   (a_waitrequest),
    .a_readdata      (a_readdata),
    .a_readdatavalid (a_readdatavalid),
    .b_address       (b_address),
    .b_read          (b_read),
    .b_burstcount    (b_burstcount),
    .b_waitrequest   (b_waitrequest),
    .b_readdata      (b_readdata),
    .b_readdatavalid (b_readdatavalid),
    .ram_chipselect  (ram_chipselect),
    .ram_write       (ram_write),
    .ram_address     (ram_address),
    .ram_byteenable  (ram_byteenable),
    .ram_writedata   (ram_writedata),
    .ram_readdata    (ram_readdata)
  );

  // Preloaded contents: word 0x010 is zero, every other word is 0xB0000000 | address.
  function automatic logic [31:0] pattern(input logic [11:0] addr);
    return (addr == 12'h010) ? 32'h0 : {20'hB0000, addr};
  endfunction

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 4096; i++) mem[i] <= pattern(12'(i));
    end else if (ram_chipselect && ram_write) begin
      for (int i = 0; i < 4; i++)
        if (ram_byteenable[i]) mem[ram_address][8*i +: 8] <= ram_writedata[8*i +: 8];
    end
    ram_readdata <= mem[ram_address];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkBus(input string tag, input logic exp_cs, input logic [11:0] exp_addr,
                          input logic exp_awr, input logic exp_bwr);
    checkOutput({tag, "_cs"}, 32'(ram_chipselect), 32'(exp_cs));
    if (exp_cs) checkOutput({tag, "_addr"}, 32'(ram_address), 32'(exp_addr));
    checkOutput({tag, "_a_waitreq"}, 32'(a_waitrequest), 32'(exp_awr));
    checkOutput({tag, "_b_waitreq"}, 32'(b_waitrequest), 32'(exp_bwr));
  endtask

  task automatic applyStimulus(input logic ard, input logic awr, input logic [11:0] aaddr,
                               input logic [3:0] abe, input logic [31:0] awd,
                               input logic brd, input logic [11:0] baddr, input logic [4:0] bbc);
    a_read = ard;  a_write = awr;  a_address = aaddr;  a_byteenable = abe;  a_writedata = awd;
    b_read = brd;  b_address = baddr;  b_burstcount = bbc;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Scoreboard monitor: every valid pulse must match the oldest expectation of its port.
  always @(negedge clk) begin
    if (a_readdatavalid) begin
      if (exp_a.size() == 0) checkOutput("a_unexpected_valid", 32'd1, 32'd0);
      else checkOutput("a_readdata", a_readdata, exp_a.pop_front());
    end
    if (b_readdatavalid) begin
      if (exp_b.size() == 0) checkOutput("b_unexpected_valid", 32'd1, 32'd0);
      else checkOutput("b_readdata", b_readdata, exp_b.pop_front());
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    preload = 1'b1;
    applyStimulus(1'b1, 1'b0, 12'h030, 4'h0, 32'h0, 1'b1, 12'h040, 5'd1);
    nextCycle();
    sample();
    checkOutput("reset_cs", 32'(ram_chipselect), 32'd0);
    checkOutput("reset_a_waitreq", 32'(a_waitrequest), 32'd1);
    checkOutput("reset_b_waitreq", 32'(b_waitrequest), 32'd1);
    checkOutput("reset_a_valid", 32'(a_readdatavalid), 32'd0);
    checkOutput("reset_b_valid", 32'(b_readdatavalid), 32'd0);
    nextCycle();
    reset_n = 1'b1;
    preload = 1'b0;

    $display("[TB] tie straight after reset");
    exp_a.push_back(pattern(12'h030));
    exp_b.push_back(pattern(12'h040));
    sample(); checkBus("tie_c1", 1'b1, 12'h030, 1'b0, 1'b1);
    nextCycle(); applyStimulus(1'b0, 1'b0, 12'h030, 4'h0, 32'h0, 1'b1, 12'h040, 5'd1);
    sample(); checkBus("tie_c2", 1'b1, 12'h040, 1'b1, 1'b0);
    checkOutput("tie_a_latency", 32'(a_readdatavalid), 32'd1);
    nextCycle(); applyStimulus(1'b1, 1'b0, 12'h031, 4'h0, 32'h0, 1'b1, 12'h041, 5'd1);
    exp_a.push_back(pattern(12'h031));
    exp_b.push_back(pattern(12'h041));
    sample(); checkBus("tie_c3", 1'b1, 12'h031, 1'b0, 1'b1);
    nextCycle(); applyStimulus(1'b0, 1'b0, 12'h031, 4'h0, 32'h0, 1'b1, 12'h041, 5'd1);
    sample(); checkBus("tie_c4", 1'b1, 12'h041, 1'b1, 1'b0);
    nextCycle(); applyStimulus(1'b0, 1'b0, 12'h0, 4'h0, 32'h0, 1'b0, 12'h0, 5'd0);
    sample(); checkOutput("tie_idle_cs", 32'(ram_chipselect), 32'd0);

    $display("[TB] A write then read with partial byteenable");
    nextCycle(); applyStimulus(1'b0, 1'b1, 12'h010, 4'b0011, 32'hDEADBEEF, 1'b0, 12'h0, 5'd0);
    sample(); checkBus("wr", 1'b1, 12'h010, 1'b0, 1'b1);
    checkOutput("wr_ram_write", 32'(ram_write), 32'd1);
    checkOutput("wr_byteenable", 32'(ram_byteenable), 32'h3);
    checkOutput("wr_writedata", ram_writedata, 32'hDEADBEEF);
    nextCycle(); applyStimulus(1'b1, 1'b0, 12'h010, 4'b0011, 32'h0, 1'b0, 12'h0, 5'd0);
    exp_a.push_back(32'h0000BEEF);
    sample(); checkBus("rd", 1'b1, 12'h010, 1'b0, 1'b1);
    checkOutput("rd_ram_write", 32'(ram_write), 32'd0);
    checkOutput("rd_byteenable", 32'(ram_byteenable), 32'hF);
    checkOutput("wr_no_valid", 32'(a_readdatavalid), 32'd0);
    nextCycle(); applyStimulus(1'b0, 1'b0, 12'h0, 4'h0, 32'h0, 1'b0, 12'h0, 5'd0);
    sample(); checkOutput("rd_latency", 32'(a_readdatavalid), 32'd1);

    $display("[TB] B burst wrapping past the top of memory, then back-to-back command");
    nextCycle(); applyStimulus(1'b0, 1'b0, 12'h0, 4'h0, 32'h0, 1'b1, 12'hFFE, 5'd4);
    for (int i = 0; i < 4; i++) exp_b.push_back(pattern(12'hFFE + 12'(i)));
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        applyStimulus(1'b0, 1'b0, 12'h0, 4'h0, 32'h0, 1'b1, 12'h020, 5'd1);
        exp_b.push_back(pattern(12'h020));
      end
      sample();
      checkBus($sformatf("wrap_c%0d", c), 1'b1, wrap_addr[c], 1'b1, wrap_bwr[c]);
      if (c > 0) checkOutput($sformatf("wrap_valid_c%0d", c), 32'(b_readdatavalid), 32'd1);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 12'h0, 4'h0, 32'h0, 1'b0, 12'h0, 5'd0);
    sample(); checkOutput("wrap_end_cs", 32'(ram_chipselect), 32'd0);
    checkOutput("wrap_end_valid", 32'(b_readdatavalid), 32'd1);

    $display("[TB] B burst of 10 with A read held: hold limit yields to A");
    nextCycle(); applyStimulus(1'b0, 1'b0, 12'h0, 4'h0, 32'h0, 1'b1, 12'h100, 5'd10);
    for (int i = 0; i < 10; i++) exp_b.push_back(pattern(12'h100 + 12'(i)));
    for (int i = 0; i < 3; i++) exp_a.push_back(pattern(12'h200));
    for (int c = 0; c < 13; c++) begin
      if (c == 1) applyStimulus(1'b1, 1'b0, 12'h200, 4'h0, 32'h0, 1'b0, 12'h0, 5'd0);
      sample();
      checkBus($sformatf("hold_c%0d", c), 1'b1, hold_addr[c], hold_awr[c], (c != 0));
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 12'h0, 4'h0, 32'h0, 1'b0, 12'h0, 5'd0);
    sample(); checkOutput("hold_end_cs", 32'(ram_chipselect), 32'd0);

    $display("[TB] burstcount clamping");
    nextCycle(); applyStimulus(1'b0, 1'b0, 12'h0, 4'h0, 32'h0, 1'b1, 12'h300, 5'd0);
    exp_b.push_back(pattern(12'h300));
    sample(); checkBus("bc0_c0", 1'b1, 12'h300, 1'b1, 1'b0);
    nextCycle(); applyStimulus(1'b0, 1'b0, 12'h0, 4'h0, 32'h0, 1'b0, 12'h0, 5'd0);
    sample(); checkOutput("bc0_one_beat", 32'(ram_chipselect), 32'd0);
    nextCycle(); applyStimulus(1'b0, 1'b0, 12'h0, 4'h0, 32'h0, 1'b1, 12'h400, 5'd31);
    for (int i = 0; i < 16; i++) exp_b.push_back(pattern(12'h400 + 12'(i)));
    sample(); checkBus("bc31_c0", 1'b1, 12'h400, 1'b1, 1'b0);
    nextCycle(); applyStimulus(1'b0, 1'b0, 12'h0, 4'h0, 32'h0, 1'b0, 12'h0, 5'd0);
    for (int c = 1; c < 16; c++) begin
      sample();
      checkBus($sformatf("bc31_c%0d", c), 1'b1, 12'h400 + 12'(c), 1'b1, 1'b1);
      nextCycle();
    end
    sample(); checkOutput("bc31_sixteen_beats", 32'(ram_chipselect), 32'd0);

    $display("[TB] reset during beat 3 of an 8-beat burst");
    nextCycle(); applyStimulus(1'b0, 1'b0, 12'h0, 4'h0, 32'h0, 1'b1, 12'h500, 5'd8);
    for (int i = 0; i < 8; i++) exp_b.push_back(pattern(12'h500 + 12'(i)));
    sample(); checkBus("rst_c0", 1'b1, 12'h500, 1'b1, 1'b0);
    nextCycle(); applyStimulus(1'b0, 1'b0, 12'h0, 4'h0, 32'h0, 1'b0, 12'h0, 5'd0);
    for (int c = 1; c < 3; c++) begin
      sample();
      checkBus($sformatf("rst_c%0d", c), 1'b1, 12'h500 + 12'(c), 1'b1, 1'b1);
      nextCycle();
    end
    #1;
    checkOutput("rst_beat3_addr", 32'(ram_address), 32'h503);
    checkOutput("rst_beat3_cs", 32'(ram_chipselect), 32'd1);
    checkOutput("rst_beat2_valid", 32'(b_readdatavalid), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("rst_cs_drop", 32'(ram_chipselect), 32'd0);
    checkOutput("rst_a_valid_drop", 32'(a_readdatavalid), 32'd0);
    checkOutput("rst_b_valid_drop", 32'(b_readdatavalid), 32'd0);
    exp_b.delete();
    nextCycle();
    nextCycle();
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sample();
      checkOutput($sformatf("post_rst_cs_c%0d", c), 32'(ram_chipselect), 32'd0);
      checkOutput($sformatf("post_rst_valid_c%0d", c), 32'(b_readdatavalid), 32'd0);
      nextCycle();
    end
    applyStimulus(1'b1, 1'b0, 12'h600, 4'h0, 32'h0, 1'b1, 12'h700, 5'd1);
    exp_a.push_back(pattern(12'h600));
    exp_b.push_back(pattern(12'h700));
    sample(); checkBus("post_rst_tie_c0", 1'b1, 12'h600, 1'b0, 1'b1);
    nextCycle(); applyStimulus(1'b0, 1'b0, 12'h0, 4'h0, 32'h0, 1'b1, 12'h700, 5'd1);
    sample(); checkBus("post_rst_tie_c1", 1'b1, 12'h700, 1'b1, 1'b0);
    nextCycle(); applyStimulus(1'b0, 1'b0, 12'h0, 4'h0, 32'h0, 1'b0, 12'h0, 5'd0);

    for (int c = 0; c < 3; c++) nextCycle();
    checkOutput("a_queue_drained", 32'(exp_a.size()), 32'd0);
    checkOutput("b_queue_drained", 32'(exp_b.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
